// File: rtl/fetch_mem_arbiter.sv
// Burst arbiter sharing one instruction-memory read port among fetch requesters.
// Define FETCH_ARB_FIXED_PRIORITY_EN for fixed priority (index 0 highest) instead of round-robin.
module fetch_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int LEN_W   = 5,
  parameter int ADDR_W  = 30
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic [NUM_REQ-1:0]        req_abort,
  output logic [NUM_REQ-1:0]        req_rvalid,
  output logic [31:0]               req_rdata,
  output logic                      mem_request,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [LEN_W-1:0]          mem_rlen,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [31:0]               mem_rdata,
  output logic                      busy
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [GW-1:0]     grant_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              discard_q;
  logic              found;
  logic [GW-1:0]     win;
  logic              abort_g;
  logic              last_word;

`ifndef FETCH_ARB_FIXED_PRIORITY_EN
  logic [GW-1:0]     rr_q;
`endif

  assign abort_g   = req_abort[grant_q];
  assign last_word = mem_rvalid && (cnt_q == len_q);
  assign mem_addr  = addr_q;
  assign mem_rlen  = len_q;
  assign busy      = (state_q != IDLE);

  // Scan downward so the lowest-priority-distance candidate is written last.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
`ifdef FETCH_ARB_FIXED_PRIORITY_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        win   = GW'(i);
      end
    end
`else
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_REQ)
        idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
`endif
  end

  always_comb begin
    state_d     = state_q;
    mem_request = 1'b0;
    req_ack     = '0;
    req_rvalid  = '0;
    req_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (found)
          state_d = ISSUE;
      end
      ISSUE: begin
        mem_request = 1'b1;
        if (mem_ack) begin
          req_ack[grant_q] = 1'b1;
          state_d          = DATA;
        end
      end
      DATA: begin
        req_rdata = mem_rdata;
        if (mem_rvalid)
          req_rvalid[grant_q] = ~discard_q & ~abort_g;
        if (last_word)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q   <= win;
            addr_q    <= req_addr[int'(win)*ADDR_W +: ADDR_W];
            len_q     <= req_len[int'(win)*LEN_W +: LEN_W];
            discard_q <= 1'b0;
          end
        end
        ISSUE: begin
          if (abort_g)
            discard_q <= 1'b1;
          if (mem_ack)
            cnt_q <= '0;
        end
        DATA: begin
          if (abort_g)
            discard_q <= 1'b1;
          if (mem_rvalid)
            cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef FETCH_ARB_FIXED_PRIORITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rr_q <= '0;
    else if (state_q == ISSUE && mem_ack)
      rr_q <= (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  end
`endif

`ifndef SYNTHESIS
  a_rvalid_onehot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_rvalid));

  a_req_stable: assert property (
    @(posedge clk) disable iff (!rst_n)
    (mem_request && !mem_ack) |=>
      (mem_request && $stable(mem_addr) && $stable(mem_rlen)));

  a_no_early_rvalid: assert property (
    @(posedge clk) disable iff (!rst_n) mem_rvalid |-> (state_q == DATA));

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_hold
    a_valid_hold: assert property (
      @(posedge clk) disable iff (!rst_n)
      (req_valid[i] && !req_ack[i] && !req_abort[i]) |=> req_valid[i]);
  end
`endif

endmodule

// File: doc/fetch_mem_arbiter.md
Name: fetch_mem_arbiter

Overview:
- Shares the single read-only instruction memory port between NUM_REQ fetch-side requesters, for example icache line fill, instruction bus prefetch and debug program-buffer reads.
- Grants one burst at a time, round-robin by default.
- Holds the port until every word of the granted burst has returned, then steers return data to the owning requester.
- Supports per-requester abort on fetch flush: remaining words of the owner's burst are drained and discarded, never delivered.

Parameters:
- NUM_REQ, 2, number of requesters (2..4)
- LEN_W, 5, burst length field width; length encoded as words-1 (max 2^LEN_W words)
- ADDR_W, 30, word address width (byte address [31:2])

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  requester i has a burst pending; held until req_ack[i]
- req_addr  in  NUM_REQ*ADDR_W  burst start word address, slice i
- req_len  in  NUM_REQ*LEN_W  burst length-1, slice i
- req_ack  out  NUM_REQ  one-cycle pulse: requester i's burst accepted by memory
- req_abort  in  NUM_REQ  flush from requester i; discard its remaining return data
- req_rvalid  out  NUM_REQ  return word valid for requester i (one-hot or zero)
- req_rdata  out  32  return word, broadcast to all requesters
- mem_request  out  1  memory request valid; held until mem_ack
- mem_addr  out  ADDR_W  granted start address
- mem_rlen  out  LEN_W  granted length-1
- mem_ack  in  1  memory accepted request
- mem_rvalid  in  1  return word valid
- mem_rdata  in  32  return word
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE; grant index 0; round-robin pointer 0; word counter 0; discard flag 0. All outputs 0 immediately, including mid-burst. In-flight memory data after reset release is not the arbiter's concern; memory is reset on the same rst_n.

State machine IDLE / ISSUE / DATA:
- IDLE:
  - If any req_valid, select winner: first asserted index at or after the rr pointer, wrapping modulo NUM_REQ.
  - Latch winner index, addr and len into registers. Clear discard.
  - Go to ISSUE next cycle. Zero-cycle grant is not permitted.
- ISSUE:
  - mem_request=1; mem_addr/mem_rlen driven from registers, stable while held.
  - On mem_ack: req_ack[grant]=1 that same cycle; rr pointer <= grant+1 (wrap); counter <= 0; go to DATA.
- DATA:
  - Each mem_rvalid: req_rdata=mem_rdata combinationally; req_rvalid[grant]=mem_rvalid & ~discard & ~req_abort[grant]; counter += 1.
  - When mem_rvalid and counter==latched len: go to IDLE.
  - A new arbitration may occur in the following IDLE cycle.
- Same-cycle mem_ack and mem_rvalid is not permitted by the memory protocol; behaviour is undefined in that case.

Abort:
- req_abort[grant] in ISSUE or DATA sets discard (sticky until IDLE).
- The request is never withdrawn from memory; the burst drains fully, with no req_rvalid from the abort cycle onward.
- Abort in ISSUE still produces req_ack on mem_ack, so the requester can release its own tracking.
- Abort from a non-granted requester has no effect on the current burst. That requester's pending req_valid is that requester's responsibility to drop.

Boundary conditions:
- len=0: single-word burst; DATA exits on the first mem_rvalid.
- len=2^LEN_W-1: counter is LEN_W bits and never wraps before matching.
- req_valid dropping without ack is a protocol violation (covered by an assertion).
- Simultaneous requests: the rr pointer decides; no starvation, with a worst-case wait of NUM_REQ-1 bursts.

Assertions:
- req_rvalid is at most one-hot.
- mem_request stable until ack.
- No mem_rvalid in IDLE/ISSUE.

Optional Feature:
- FETCH_ARB_FIXED_PRIORITY_EN
- Defined: the rr pointer is removed; the winner is always the lowest asserted index (index 0 highest priority, e.g. icache fill).
- Undefined: round-robin as above.
- Interface and latency are identical in both cases.

Test Plan:
- Single request: req_valid[0], addr 0x100, len 3; mem_ack 2 cycles after mem_request; 4 rvalid words → req_ack[0] pulses once, req_rvalid[0] exactly 4 times with the matching data, busy drops the cycle after the 4th word, mem_addr=0x100, mem_rlen=3.
- Round-robin: req 0 and 1 held continuously, len 0 each → grants alternate 0,1,0,1; under FETCH_ARB_FIXED_PRIORITY_EN, all grants go to 0 while it stays valid.
- Abort mid-burst: len 7, req_abort[grant] asserted after word 2 → req_rvalid only for words 0–2; FSM returns to IDLE only after the 8th mem_rvalid.
- Abort in ISSUE: abort before mem_ack, len 1 → req_ack still pulses; zero req_rvalid; both words consumed.
- Async reset mid-DATA: rst_n low between words 1 and 2 of a len-3 burst → mem_request, req_rvalid and busy go to 0 without a clock edge; after release, a new request to index 1 is granted first (rr pointer reset to 0; index 0 idle).
- Max length: len 31 → exactly 32 req_rvalid, counter does not wrap early, IDLE reached after the 32nd word.
